// File: rtl/hex_display_scanner.sv
// Time-multiplexed scanner feeding one hex-to-7-segment decoder across DIGITS digits.
// New values take effect only at frame boundaries so a frame never mixes old and new digits.
module hex_display_scanner #(
  parameter int DIGITS        = 4,
  parameter int CLK_DIV       = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic [3:0]            num,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  blank,
  output logic                  frame_done
);

  localparam int VAL_W = 4 * DIGITS;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]  div_cnt, div_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic [VAL_W-1:0]  shadow, shadow_next;
  logic [VAL_W-1:0]  pend_val, pend_val_next;
  logic              pending, pending_next;
  logic              tc, boundary;
  logic [DIGITS-1:0] upper_zero;
  logic [3:0]        num_next;
  logic [DIGITS-1:0] digit_en_next;
  logic              blank_next;

  always_comb begin
    tc            = (div_cnt == DIV_LAST);
    boundary      = tc && (idx == IDX_LAST);
    div_next      = tc ? '0 : div_cnt + 1'b1;
    idx_next      = idx;
    shadow_next   = shadow;
    pend_val_next = pend_val;
    pending_next  = pending;

    if (tc) begin
      idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end

    // A load landing on the boundary itself bypasses the pending slot entirely
    if (boundary) begin
      if (load) begin
        shadow_next = value;
      end else if (pending) begin
        shadow_next = pend_val;
      end
      pending_next = 1'b0;
    end else if (load) begin
      pend_val_next = value;
      pending_next  = 1'b1;
    end
  end

  // upper_zero[i] is set when nibbles i..DIGITS-1 of the next displayed value are all zero
  for (genvar g = 0; g < DIGITS; g++) begin : g_zero
    assign upper_zero[g] = (shadow_next[VAL_W-1:4*g] == '0);
  end

  always_comb begin
    num_next      = shadow_next[4*idx_next +: 4];
    digit_en_next = DIGITS'(1) << idx_next;
    blank_next    = (BLANK_LEADING != 0) && (idx_next != '0) && upper_zero[idx_next];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      idx        <= '0;
      shadow     <= '0;
      pend_val   <= '0;
      pending    <= 1'b0;
      num        <= 4'h0;
      digit_en   <= DIGITS'(1);
      blank      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      div_cnt    <= div_next;
      idx        <= idx_next;
      shadow     <= shadow_next;
      pend_val   <= pend_val_next;
      pending    <= pending_next;
      num        <= num_next;
      digit_en   <= digit_en_next;
      blank      <= blank_next;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner: per-cycle scoreboard plus table-driven frame checks.
// Two instances share stimulus so leading-zero blanking can be compared with blanking disabled.
module tb_hex_display_scanner;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = DIGITS * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  num, num_nb;
  logic [3:0]  digit_en, digit_en_nb;
  logic        blank, blank_nb;
  logic        frame_done, frame_done_nb;

  hex_display_scanner #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .num(num), .digit_en(digit_en), .blank(blank), .frame_done(frame_done)
  );

  hex_display_scanner #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_LEADING(0)) dut_nb (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .num(num_nb), .digit_en(digit_en_nb), .blank(blank_nb), .frame_done(frame_done_nb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] digit_en;
    logic [3:0] num;
    logic       blank;
    logic       frame_done;
  } out_t;

  typedef struct {
    string       name;
    logic [15:0] v1;
    int          p1;
    logic [15:0] v2;
    int          p2;
    logic [15:0] exp_val;
    logic [3:0]  exp_blank;
  } vec_t;

  out_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n = 0;
  logic [15:0] m_shown = 16'h0;
  logic [15:0] m_pend = 16'h0;
  logic        m_pending = 1'b0;
  logic [15:0] cap_num;
  logic [3:0]  cap_blank, cap_blank_nb;
  vec_t        vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic blankFor(input int d, input logic [15:0] shown);
    return (d != 0) && ((shown >> (4 * d)) == 16'h0);
  endfunction

  task automatic captureNow();
    for (int d = 0; d < DIGITS; d++) begin
      if (digit_en[d]) begin
        cap_num[4*d +: 4] = num;
        cap_blank[d]      = blank;
        cap_blank_nb[d]   = blank_nb;
      end
    end
  endtask

  // Drives one cycle and queues the outputs expected right after that clock edge
  task automatic applyStimulus(input logic rst_v, input logic load_v, input logic [15:0] value_v);
    out_t e;
    int   pos;
    int   d;
    rst   = rst_v;
    load  = load_v;
    value = value_v;
    if (rst_v) begin
      m_shown    = 16'h0;
      m_pend     = 16'h0;
      m_pending  = 1'b0;
      n          = 0;
      e.digit_en   = 4'b0001;
      e.num        = 4'h0;
      e.blank      = 1'b0;
      e.frame_done = 1'b0;
    end else begin
      n++;
      if (n % FRAME == 0) begin
        if (load_v) m_shown = value_v;
        else if (m_pending) m_shown = m_pend;
        m_pending = 1'b0;
      end else if (load_v) begin
        m_pend    = value_v;
        m_pending = 1'b1;
      end
      pos = n % FRAME;
      d   = pos / CLK_DIV;
      e.digit_en   = 4'(1) << d;
      e.num        = m_shown[4*d +: 4];
      e.blank      = blankFor(d, m_shown);
      e.frame_done = (pos == 0);
    end
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    load = 1'b0;
    captureNow();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 16'($urandom));
  endtask

  task automatic runToPos(input int p);
    for (int k = 0; k < FRAME && (n % FRAME) != p; k++) idleCycle();
  endtask

  // Must start at the first cycle of a frame; records what each digit showed
  task automatic captureFrame(input string name, input logic [15:0] exp_val, input logic [3:0] exp_blank);
    cap_num      = 'x;
    cap_blank    = 'x;
    cap_blank_nb = 'x;
    captureNow();
    for (int k = 1; k < FRAME; k++) idleCycle();
    checkOutput({name, "_num"}, 32'(cap_num), 32'(exp_val));
    checkOutput({name, "_blank"}, 32'(cap_blank), 32'(exp_blank));
    checkOutput({name, "_blank_nb"}, 32'(cap_blank_nb), 32'(4'b0000));
  endtask

  always @(negedge clk) begin : monitor
    out_t e;
    out_t e_nb;
    if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      e_nb = e;
      e_nb.blank = 1'b0;
      checkOutput("outputs", 32'({digit_en, num, blank, frame_done}), 32'(e));
      checkOutput("outputs_nb", 32'({digit_en_nb, num_nb, blank_nb, frame_done_nb}), 32'(e_nb));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{"load_mid",     16'hA3F0, 6,  16'h0000, -1, 16'hA3F0, 4'b0000};
    vecs[1] = '{"lead_zero",    16'h0050, 9,  16'h0000, -1, 16'h0050, 4'b1100};
    vecs[2] = '{"latest_wins",  16'h1111, 2,  16'h2222, 11, 16'h2222, 4'b0000};
    vecs[3] = '{"bypass",       16'hBEEF, 15, 16'h0000, -1, 16'hBEEF, 4'b0000};
    vecs[4] = '{"single_digit", 16'h0007, 0,  16'h0000, -1, 16'h0007, 4'b1110};

    applyStimulus(1'b1, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    captureFrame("reset_frame0", 16'h0000, 4'b1110);
    captureFrame("reset_frame1", 16'h0000, 4'b1110);

    foreach (vecs[i]) begin
      runToPos(vecs[i].p1);
      applyStimulus(1'b0, 1'b1, vecs[i].v1);
      if (vecs[i].p2 >= 0) begin
        runToPos(vecs[i].p2);
        applyStimulus(1'b0, 1'b1, vecs[i].v2);
      end
      runToPos(0);
      captureFrame(vecs[i].name, vecs[i].exp_val, vecs[i].exp_blank);
      runToPos(0);
      captureFrame({vecs[i].name, "_again"}, vecs[i].exp_val, vecs[i].exp_blank);
    end

    // Reset while digit 2 is lit and a load is still waiting for the boundary
    runToPos(3);
    applyStimulus(1'b0, 1'b1, 16'h9999);
    runToPos(9);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("rst_mid_digit_en", 32'(digit_en), 32'(4'b0001));
    checkOutput("rst_mid_num", 32'(num), 32'(4'h0));
    captureFrame("rst_mid_frame0", 16'h0000, 4'b1110);
    runToPos(0);
    captureFrame("rst_mid_frame1", 16'h0000, 4'b1110);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Time-multiplexing scanner sitting directly upstream of binary_to_hex_7segDecoder.
- Holds a DIGITS-nibble hex value and presents one nibble at a time on num, which feeds the decoder's num input.
- Drives one-hot digit enables and a blank flag, so one decoder instance serves a multi-digit common-segment display.
- New values are accepted only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
- DIGITS, 4, number of display digits (2..8).
- CLK_DIV, 50000, clock cycles each digit stays lit (>=2).
- BLANK_LEADING, 1, 1 = blank leading zero digits; 0 = show all digits.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- load  input  1  single-cycle strobe: capture value.
- value  input  4*DIGITS  hex value; nibble i = value[4i+3:4i]; digit 0 is least significant.
- num  output  4  nibble for the current digit, to the decoder's num input.
- digit_en  output  DIGITS  one-hot active-high enable of the lit digit.
- blank  output  1  1 = current digit must be dark; downstream forces segments off.
- frame_done  output  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Clock and reset:
  - Single clock domain clk.
  - rst is synchronous and active-high.
  - Reset mid-operation aborts the scan immediately and discards any pending load.
- Registers:
  - div_cnt, 0..CLK_DIV-1.
  - idx, 0..DIGITS-1.
  - shadow, the displayed value (4*DIGITS).
  - pend_val (4*DIGITS) and pending (1).
- Reset values:
  - div_cnt=0, idx=0, shadow=0, pending=0, pend_val=0.
  - num=0, digit_en=1 (digit 0 lit), blank=0, frame_done=0.
- Divider:
  - div_cnt increments every cycle.
  - At CLK_DIV-1 (terminal count, tc), div_cnt wraps to 0 and idx advances.
  - idx wraps from DIGITS-1 to 0.
- Output registers:
  - num, digit_en and blank are registered and all change in the same cycle.
  - They are computed from the next idx and next shadow, so they track idx and shadow with zero added latency.
  - Each digit is lit for exactly CLK_DIV cycles; frame period = DIGITS*CLK_DIV cycles.
- Frame boundary: the tc cycle with idx = DIGITS-1.
  - frame_done is 1 in the cycle after it.
  - If pending=1, shadow <= pend_val and pending <= 0, so the new value is displayed starting with digit 0.
- load rules:
  - load on a non-boundary cycle: pend_val <= value, pending <= 1.
  - load while already pending: pend_val is overwritten (latest wins).
  - load on the boundary cycle itself: value goes directly to shadow and pending is cleared (bypass, no extra frame of delay).
- Blanking:
  - With BLANK_LEADING=1, digit i (i>0) is blanked when shadow nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never blanked, so value 0 shows "0".
  - With BLANK_LEADING=0, blank is always 0.
  - num still carries the nibble while blanked.
- digit_en is never all-zero after reset and never has more than one bit set.

Test Plan:
1. Reset/scan: DIGITS=4, CLK_DIV=4, rst high 2 cycles then low.
   - digit_en = 0001, 0010, 0100, 1000, repeating every 4 cycles.
   - num=0 throughout.
   - blank=1 on digits 1-3.
   - frame_done pulses every 16 cycles.
2. Load applied at frame boundary: load with value=16'hA3F0 mid-frame.
   - Current frame keeps old digits.
   - Next frame shows num = 0, F, 3, A on digits 0..3; blank=0 on all digits.
3. Leading-zero blanking: value=16'h0050, BLANK_LEADING=1.
   - Digits 0,1 unblanked (num 0, 5); digits 2,3 blank=1.
   - With BLANK_LEADING=0: all blank=0.
4. Latest wins: two loads, 16'h1111 then 16'h2222, within one frame.
   - Next frame shows 2,2,2,2; value 1111 is never displayed.
5. Bypass: load 16'hBEEF exactly on the boundary tc cycle.
   - Digit 0 of the immediately following frame shows F.
   - No pending is left (a later frame still shows BEEF).
6. Reset mid-operation: assert rst during digit 2 with a load pending.
   - Next cycle: digit_en=0001, num=0, shadow=0.
   - The pending value is never shown.
